intgen_multi: RTL and testbench

INTGEN_MULTI -- requirements
Module: intgen_multi

---
 rtl/intgen_multi.sv | 129 ++++++++++++
 tb/tb_intgen_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intgen_multi.sv
// Multi-channel countdown interrupt generator behind a Wishbone classic slave.
// Define INTGEN_MULTI_PERIODIC_EN to add the per-channel MODE bit and LOAD reload register.
module intgen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  localparam int AW    = $clog2(NUM_CH) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [NUM_CH-1:0] irq_o,
  output logic              irq_any_o
);

  // Handshake: a request is cyc&stb held with a stable address. Ack (or err for an
  // out-of-range channel) rises one cycle later for exactly one cycle; a write commits
  // on the edge that ends the ack cycle, and only if cyc&stb are still high then.
  logic [AW-1:0]    ch_idx;
  logic             sel;
  logic             ch_ok;
  logic             req;
  logic             commit;
  logic             ack_q;
  logic             err_q;
  logic [31:0]      dat_q;
  logic [31:0]      rdata;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] ien;
  logic [NUM_CH-1:0] mode;
  logic [CNT_W-1:0] cnt_v [NUM_CH];
  logic             unused_dat;

  assign ch_idx     = AW'(wb_adr_i >> 1);
  assign sel        = wb_adr_i[0];
  assign ch_ok      = (ch_idx < AW'(NUM_CH));
  assign req        = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign commit     = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
  assign unused_dat = ^wb_dat_i;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == AW'(i)) begin
        rdata = sel ? {29'd0, pend[i], ien[i], mode[i]} : 32'(cnt_v[i]);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req & ch_ok;
      err_q <= req & ~ch_ok;
      dat_q <= (req & ch_ok) ? rdata : '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             hit;
    logic             wr_cnt;
    logic             wr_ctl;
    logic             expire;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] reload;
    logic             pend_r;
    logic             ien_r;
    logic             mode_r;

    assign hit    = commit && (ch_idx == AW'(g));
    assign wr_cnt = hit & ~sel;
    assign wr_ctl = hit & sel;
    assign expire = (cnt_r == CNT_W'(1));

`ifdef INTGEN_MULTI_PERIODIC_EN
    logic [CNT_W-1:0] load_r;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
        load_r <= '0;
        mode_r <= 1'b0;
      end else begin
        if (wr_cnt) load_r <= wb_dat_i[CNT_W-1:0];
        if (wr_ctl) mode_r <= wb_dat_i[0];
      end
    end
    assign reload = mode_r ? load_r : '0;
`else
    assign mode_r = 1'b0;
    assign reload = '0;
`endif

    // A COUNT write overrides both the decrement and any expiry due on the same edge;
    // an expiry beats a simultaneous PEND clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
        cnt_r  <= '0;
        pend_r <= 1'b0;
        ien_r  <= 1'b0;
      end else begin
        if (wr_cnt)             cnt_r <= wb_dat_i[CNT_W-1:0];
        else if (expire)        cnt_r <= reload;
        else if (cnt_r != '0)   cnt_r <= cnt_r - CNT_W'(1);
        if (wr_ctl) ien_r <= wb_dat_i[1];
        pend_r <= (expire & ~wr_cnt) | (pend_r & ~(wr_ctl & wb_dat_i[2]));
      end
    end

    assign cnt_v[g] = cnt_r;
    assign pend[g]  = pend_r;
    assign ien[g]   = ien_r;
    assign mode[g]  = mode_r;
  end

  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_dat_o  = dat_q;
  assign irq_o     = pend & ien;
  assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_intgen_multi.sv
// Directed bench for intgen_multi (NUM_CH=3) with an expiry-time model of every channel.
// Honours INTGEN_MULTI_PERIODIC_EN the same way the design does.
module tb_intgen_multi;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int AW     = $clog2(NUM_CH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     adr = '0;
  logic [31:0]       dat_i = '0;
  logic              we = 1'b0;
  logic              cyc = 1'b0;
  logic              stb = 1'b0;
  logic [31:0]       dat_o;
  logic              ack;
  logic              err;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;

  intgen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o),
    .wb_ack_o(ack), .wb_err_o(err), .irq_o(irq), .irq_any_o(irq_any)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: each channel is an absolute expiry cycle ----------------
  int  cyc_n;
  int  m_next [NUM_CH];
  int  m_load [NUM_CH];
  bit  m_pend [NUM_CH];
  bit  m_ien  [NUM_CH];
  bit  m_mode [NUM_CH];
  bit          c_valid;
  int          c_ch;
  bit          c_sel;
  logic [31:0] c_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_n   = 0;
      c_valid = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_next[i] = -1; m_load[i] = 0; m_pend[i] = 0; m_ien[i] = 0; m_mode[i] = 0;
      end
    end else begin
      cyc_n++;
      for (int i = 0; i < NUM_CH; i++) begin
        bit expire;
        bit clr;
        expire = (m_next[i] == cyc_n);
        clr    = 0;
        if (c_valid && c_ch == i && !c_sel) begin
          m_load[i] = int'(c_dat[CNT_W-1:0]);
          m_next[i] = (m_load[i] == 0) ? -1 : cyc_n + m_load[i];
          expire    = 0;
        end else if (expire) begin
          m_next[i] = m_mode[i] ? cyc_n + m_load[i] : -1;
        end
        if (c_valid && c_ch == i && c_sel) begin
          clr      = c_dat[2];
          m_ien[i] = c_dat[1];
`ifdef INTGEN_MULTI_PERIODIC_EN
          m_mode[i] = c_dat[0];
`endif
        end
        m_pend[i] = expire | (m_pend[i] & ~clr);
      end
      c_valid = 0;
    end
  end

  function automatic logic [31:0] model_cnt(input int ch);
    return (m_next[ch] < 0) ? 32'd0 : 32'(m_next[ch] - cyc_n);
  endfunction

  // ---------------- compare process: interrupt outputs every cycle ----------------
  always @(negedge clk) begin
    logic [NUM_CH-1:0] e;
    for (int i = 0; i < NUM_CH; i++) e[i] = m_pend[i] & m_ien[i];
    check("irq_o", 32'(irq), 32'(e));
    check("irq_any_o", 32'(irq_any), 32'(|e));
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic bus(input bit w, input int ch, input bit s, input logic [31:0] d,
                     input bit abort, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic [31:0] chv;
    bit ok;
    ok     = (ch < NUM_CH);
    exp_rd = !ok ? 32'd0 : (s ? {29'd0, m_pend[ch], m_ien[ch], m_mode[ch]} : model_cnt(ch));
    chv    = 32'(ch);
    adr    = {chv[AW-2:0], s};
    dat_i  = d; we = w; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check("ack", 32'(ack), 32'(ok));
    check("err", 32'(err), 32'(!ok));
    if (!w || !ok) check("dat_o", dat_o, exp_rd);
    rd = dat_o;
    if (abort) begin
      cyc = 1'b0; stb = 1'b0;
    end else if (w && ok) begin
      c_valid = 1; c_ch = ch; c_sel = s; c_dat = d;
    end
    @(negedge clk);
    check("ack_one_cycle", 32'(ack), 32'd0);
    check("err_one_cycle", 32'(err), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int ch, input bit s, input logic [31:0] d);
    logic [31:0] rd;
    bus(1'b1, ch, s, d, 1'b0, rd);
  endtask

  task automatic rdr(input int ch, input bit s, output logic [31:0] rd);
    bus(1'b0, ch, s, 32'd0, 1'b0, rd);
  endtask

  task automatic wait_irq(input int ch, input int max, output int t, output bit hit);
    hit = 0; t = -1;
    for (int k = 0; k < max && !hit; k++) begin
      @(negedge clk);
      if (irq[ch]) begin hit = 1; t = cyc_n; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int t [3];
    int fires;
    bit hit;

    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rdr(0, 1'b1, rd); check("rst_ctrl0", rd, 32'd0);
    rdr(0, 1'b0, rd); check("rst_cnt0", rd, 32'd0);

    // ch2 count 5 with IEN: irq exactly 5 edges after the commit edge
    wr(2, 1'b1, 32'h2);
    wr(2, 1'b0, 32'd5);
    repeat (4) @(negedge clk);
    check("ch2_before_expiry", 32'(irq), 32'b000);
    @(negedge clk);
    check("ch2_at_expiry", 32'(irq), 32'b100);
    rdr(2, 1'b0, rd); check("ch2_cnt_after", rd, 32'd0);
    wr(2, 1'b1, 32'h6);

    // masked expiry, then unmask
    wr(1, 1'b0, 32'd2);
    repeat (3) @(negedge clk);
    check("masked_irq", 32'(irq), 32'b000);
    rdr(1, 1'b1, rd); check("masked_ctrl", rd, 32'h4);
    wr(1, 1'b1, 32'h2);
    check("unmask_irq", 32'(irq), 32'b010);
    wr(1, 1'b1, 32'h6);

    // periodic ch0 LOAD=3, cleared on every interrupt
    wr(0, 1'b1, 32'h3);
    wr(0, 1'b0, 32'd3);
    fires = 0;
    for (int k = 0; k < 3; k++) begin
      wait_irq(0, 8, t[k], hit);
      if (hit) begin
        fires++;
        wr(0, 1'b1, 32'h7);
      end
    end
`ifdef INTGEN_MULTI_PERIODIC_EN
    check("periodic_fires", 32'(fires), 32'd3);
    check("periodic_gap1", 32'(t[1] - t[0]), 32'd3);
    check("periodic_gap2", 32'(t[2] - t[1]), 32'd3);
`else
    check("oneshot_fires", 32'(fires), 32'd1);
`endif
    wr(0, 1'b0, 32'd0);
    wr(0, 1'b1, 32'h4);

    // LOAD=1: counter holds at 1 when periodic
    wr(0, 1'b1, 32'h1);
    wr(0, 1'b0, 32'd1);
    repeat (4) @(negedge clk);
    rdr(0, 1'b0, rd);
`ifdef INTGEN_MULTI_PERIODIC_EN
    check("load1_cnt", rd, 32'd1);
`else
    check("load1_cnt", rd, 32'd0);
`endif
    wr(0, 1'b0, 32'd0);
    wr(0, 1'b1, 32'h4);

    // expiry coincides with a PEND clear: set wins
    wr(2, 1'b0, 32'd1);
    wr(2, 1'b0, 32'd2);
    wr(2, 1'b1, 32'h6);
    check("set_wins_irq", 32'(irq[2]), 32'd1);

    // restart discards the expiry due on the write edge
    wr(1, 1'b0, 32'd2);
    wr(1, 1'b0, 32'd4);
    check("restart_no_irq", 32'(irq[1]), 32'd0);
    repeat (3) @(negedge clk);
    check("restart_pre", 32'(irq[1]), 32'd0);
    @(negedge clk);
    check("restart_fire", 32'(irq[1]), 32'd1);
    wr(1, 1'b1, 32'h6);

    // aborted write, out-of-range channel, zero count
    bus(1'b1, 0, 1'b0, 32'd7, 1'b1, rd);
    @(negedge clk);
    rdr(0, 1'b0, rd); check("abort_cnt", rd, 32'd0);
    wr(3, 1'b0, 32'd5);
    rdr(3, 1'b1, rd); check("err_dat", rd, 32'd0);
    wr(0, 1'b0, 32'd3);
    wr(0, 1'b0, 32'd0);
    repeat (5) @(negedge clk);
    rdr(0, 1'b1, rd); check("zero_ctrl", rd, 32'd0);

    // reset while ch1 counts and an ack is pending
    wr(1, 1'b0, 32'd10);
    adr = 3'b010; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ack", 32'(ack), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_dat", dat_o, 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    check("async_rst_any", 32'(irq_any), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("post_rst_ack", 32'(ack), 32'd0);
      check("post_rst_err", 32'(err), 32'd0);
    end
    rdr(1, 1'b0, rd); check("post_rst_cnt1", rd, 32'd0);
    rdr(2, 1'b1, rd); check("post_rst_ctrl2", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
